button_pio_rx: RTL and testbench
================================

// Module: button_pio_rx
// PURPOSE
//  Input-direction counterpart of the LED output PIO: an Avalon-MM slave that samples the
//  board push-buttons, then synchronises, debounces and edge-captures them for the host over PCIe.
//  It sits inside the PCIe system on the fabric clock and raises a level IRQ on masked button presses.
//  Buttons are active-low at the pins. Every register bit reads '1' = pressed.
// PARAMETERS
//  WIDTH            4       number of button inputs (1..32)
//  DEBOUNCE_CYCLES  500000  consecutive stable clk cycles needed to accept a change (10 ms @ 50 MHz)
//  CNT_W            $clog2(DEBOUNCE_CYCLES) (local)  debounce counter width
// PORTS
//  clk            in   1      single fabric clock; all logic on its rising edge
//  rstn           in   1      synchronous reset, active-low
//  botones        in   WIDTH  raw asynchronous button pins, active-low
//  avs_address    in   2      word address: 0 DATA, 1 IRQ_MASK, 2 reserved, 3 EDGE_CAPTURE
//  avs_read       in   1      read strobe, single cycle
//  avs_write      in   1      write strobe, single cycle
//  avs_writedata  in   32     write data
//  avs_readdata   out  32     read data, valid with avs_readdatavalid
//  avs_readdatavalid out 1    one-cycle pulse, one clk after avs_read
//  irq            out  1      level interrupt = |(EDGE_CAPTURE & IRQ_MASK), registered
// BEHAVIOUR
//  Reset (rstn=0 at a clk edge) has these effects:
//   - sync FFs go to all-1 (released).
//   - debounced state goes to 0 (not pressed).
//   - counters go to 0.
//   - IRQ_MASK and EDGE_CAPTURE go to 0.
//   - avs_readdata, avs_readdatavalid and irq go to 0.
//   - Reset mid-debounce discards the partial count, and no edge is produced.
//  Synchroniser: 2-FF chain per bit. pressed_s = ~sync2.
//  Debounce, per bit, independent counters:
//   - If pressed_s == stable: cnt <= 0.
//   - Else if cnt == DEBOUNCE_CYCLES-1: stable <= pressed_s, cnt <= 0.
//   - Else: cnt <= cnt+1.
//   => A pin change held for 2+DEBOUNCE_CYCLES clk appears in DATA. Shorter pulses are ignored entirely.
//  Edge capture: on the cycle stable goes 0->1, EDGE_CAPTURE[i] <= 1 (sticky). Release (1->0) is not captured.
//  Register map, bits [31:WIDTH] read 0:
//   - 0 DATA: RO, stable[WIDTH-1:0]. Writes are ignored.
//   - 1 IRQ_MASK: RW, [WIDTH-1:0].
//   - 2 reserved: reads 0, writes ignored.
//   - 3 EDGE_CAPTURE: RO/W1C. Writing 1 clears the bit, writing 0 leaves it.
//  Set/clear collision: if a new press and a W1C of the same bit occur in one cycle, set wins (bit stays 1).
//  Read timing: fixed latency 1, no waitrequest.
//   - avs_read at edge N -> avs_readdata/avs_readdatavalid=1 at edge N+1.
//   - avs_readdata holds until the next read.
//  Read and write in the same cycle: both are performed, and the read returns the pre-write value.
//  irq = registered OR of (EDGE_CAPTURE & IRQ_MASK).
//   - It is asserted the clk after the edge bit or mask bit becomes 1.
//   - It is deasserted the clk after the last masked bit clears.
//  Back-to-back reads on consecutive cycles are supported at full rate.
// TESTING  (bench uses WIDTH=4, DEBOUNCE_CYCLES=4)
//  1 Hold rstn=0 for 2 clk with botones=4'hF -> all outputs 0; read addr 0/1/3 -> 0x0 each, valid 1 clk after read.
//  2 botones[0]=0 held 10 clk -> DATA=0x1 exactly 6 clk after pin falls; EDGE=0x1; release 10 clk -> DATA=0x0, EDGE still 0x1.
//  3 botones[1]=0 for 3 clk only -> DATA and EDGE remain 0x0; irq stays 0.
//  4 Write IRQ_MASK=0x1, then press bit0 -> irq=1 one clk after EDGE[0] sets.
//    Write 0x1 to addr 3 -> EDGE=0, and irq=0 next clk.
//    Then W1C in the same cycle as a new edge -> EDGE[0] stays 1.
//  5 Press bit2, pull rstn=0 when cnt=2, release rstn with pin still low -> EDGE=0.
//    DATA=0x4 only after a full 4-cycle recount.
//  6 Write 0xFFFFFFFF to addr 0 and addr 2 -> no state change; read addr 2 -> 0x0; read+write addr 1 same cycle -> old mask returned.

Source files
------------

// File: rtl/button_pio_rx.sv
// Avalon-MM push-button input PIO: synchronises, debounces and edge-captures
// active-low button pins and raises a level IRQ on masked presses.
module button_pio_rx #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] botones,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgeCap_q, edgeCap_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clearBits;
  logic [31:0]      readMux;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q;
  logic             irq_q;
  logic             unusedWdata;

  assign pressed     = ~sync2_q;
  assign unusedWdata = ^avs_writedata;

  // A bit only changes after CNT_MAX+1 consecutive cycles of disagreement.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (pressed[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = pressed[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A press landing in the same cycle as a W1C of that bit keeps it set.
  always_comb begin
    rise      = stable_d & ~stable_q;
    clearBits = (avs_write && avs_address == ADDR_EDGE) ?
                avs_writedata[WIDTH-1:0] : '0;
    edgeCap_d = (edgeCap_q & ~clearBits) | rise;
    mask_d    = (avs_write && avs_address == ADDR_MASK) ?
                avs_writedata[WIDTH-1:0] : mask_q;
  end

  always_comb begin
    readMux = '0;
    case (avs_address)
      ADDR_DATA: readMux[WIDTH-1:0] = stable_q;
      ADDR_MASK: readMux[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readMux[WIDTH-1:0] = edgeCap_q;
      default:   readMux = '0;
    endcase
    rdata_d = avs_read ? readMux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      stable_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      mask_q    <= '0;
      edgeCap_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sync1_q   <= botones;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      edgeCap_q <= edgeCap_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= avs_read;
      irq_q     <= |(edgeCap_q & mask_q);
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq               = irq_q;

endmodule

// File: tb/tb_button_pio_rx.sv
// Directed self-checking bench for button_pio_rx with a short debounce window
// (WIDTH=4, DEBOUNCE_CYCLES=4) so every timing boundary is hand-countable.
module tb_button_pio_rx;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  botones;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;

  int checks = 0;
  int errors = 0;

  button_pio_rx #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .botones           (botones),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  // Every sample and every drive happens 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic rd,
                               input logic wr, input logic [31:0] wdata);
    avs_address   = addr;
    avs_read      = rd;
    avs_write     = wr;
    avs_writedata = wdata;
    tick(1);
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
  endtask

  task automatic readReg(input string tag, input logic [1:0] addr,
                         input logic [31:0] exp);
    applyStimulus(addr, 1'b1, 1'b0, 32'h0);
    checkOutput({tag, " valid"}, {31'b0, avs_readdatavalid}, 32'h1);
    checkOutput(tag, avs_readdata, exp);
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    applyStimulus(addr, 1'b0, 1'b1, data);
  endtask

  initial begin
    rstn          = 1'b0;
    botones       = 4'hF;
    avs_address   = 2'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;

    // Reset values and single-cycle read latency
    tick(2);
    checkOutput("rst readdata", avs_readdata, 32'h0);
    checkOutput("rst valid", {31'b0, avs_readdatavalid}, 32'h0);
    checkOutput("rst irq", {31'b0, irq}, 32'h0);
    rstn = 1'b1;
    readReg("rst DATA", 2'd0, 32'h0);
    readReg("rst MASK", 2'd1, 32'h0);
    readReg("rst EDGE", 2'd3, 32'h0);
    tick(1);
    checkOutput("valid one cycle", {31'b0, avs_readdatavalid}, 32'h0);

    // Press bit0: stable sets on the 6th edge after the pin falls, so a
    // back-to-back DATA read shows it from the 7th edge onwards.
    avs_address = 2'd0;
    avs_read    = 1'b1;
    botones     = 4'hE;
    tick(6);
    checkOutput("press edge6 DATA", avs_readdata, 32'h0);
    tick(1);
    checkOutput("press edge7 DATA", avs_readdata, 32'h1);
    avs_read = 1'b0;
    tick(3);
    readReg("press EDGE", 2'd3, 32'h1);
    botones = 4'hF;
    tick(10);
    readReg("release DATA", 2'd0, 32'h0);
    readReg("release EDGE", 2'd3, 32'h1);
    writeReg(2'd3, 32'h1);
    readReg("w1c EDGE", 2'd3, 32'h0);

    // 3-cycle glitch on bit1 is rejected
    botones = 4'hD;
    tick(3);
    botones = 4'hF;
    tick(8);
    readReg("glitch DATA", 2'd0, 32'h0);
    readReg("glitch EDGE", 2'd3, 32'h0);
    checkOutput("glitch irq", {31'b0, irq}, 32'h0);

    // Masked IRQ, W1C clear, release not captured, set-wins collision
    writeReg(2'd1, 32'h1);
    readReg("mask rd", 2'd1, 32'h1);
    botones = 4'hE;
    tick(6);
    checkOutput("irq same edge", {31'b0, irq}, 32'h0);
    tick(1);
    checkOutput("irq next edge", {31'b0, irq}, 32'h1);
    readReg("irq EDGE", 2'd3, 32'h1);
    writeReg(2'd3, 32'h1);
    checkOutput("irq at w1c", {31'b0, irq}, 32'h1);
    tick(1);
    checkOutput("irq after w1c", {31'b0, irq}, 32'h0);
    readReg("cleared EDGE", 2'd3, 32'h0);
    botones = 4'hF;
    tick(10);
    readReg("no release edge", 2'd3, 32'h0);
    botones = 4'hE;
    tick(5);
    applyStimulus(2'd3, 1'b0, 1'b1, 32'h1);
    readReg("collision EDGE", 2'd3, 32'h1);
    checkOutput("collision irq", {31'b0, irq}, 32'h1);
    botones = 4'hF;
    tick(10);

    // Reset while bit2 has cnt=2 discards the count; recount is full length
    botones = 4'hB;
    tick(4);
    rstn = 1'b0;
    tick(1);
    checkOutput("midrst irq", {31'b0, irq}, 32'h0);
    checkOutput("midrst valid", {31'b0, avs_readdatavalid}, 32'h0);
    rstn        = 1'b1;
    avs_read    = 1'b1;
    avs_address = 2'd3;
    tick(1);
    checkOutput("midrst EDGE", avs_readdata, 32'h0);
    avs_address = 2'd0;
    tick(5);
    checkOutput("recount edge6 DATA", avs_readdata, 32'h0);
    tick(1);
    checkOutput("recount edge7 DATA", avs_readdata, 32'h4);
    avs_read = 1'b0;
    readReg("midrst MASK", 2'd1, 32'h0);
    checkOutput("midrst irq unmasked", {31'b0, irq}, 32'h0);

    // Ignored writes, reserved address, read+write ordering, upper bits
    writeReg(2'd0, 32'hFFFF_FFFF);
    writeReg(2'd2, 32'hFFFF_FFFF);
    readReg("ro DATA", 2'd0, 32'h4);
    readReg("rsvd", 2'd2, 32'h0);
    readReg("post EDGE", 2'd3, 32'h4);
    readReg("post MASK", 2'd1, 32'h0);
    writeReg(2'd1, 32'h3);
    applyStimulus(2'd1, 1'b1, 1'b1, 32'hA);
    checkOutput("rw old mask", avs_readdata, 32'h3);
    readReg("rw new mask", 2'd1, 32'hA);
    writeReg(2'd1, 32'hFFFF_FFFF);
    readReg("mask upper", 2'd1, 32'hF);
    checkOutput("final irq", {31'b0, irq}, 32'h1);
    tick(1);
    checkOutput("readdata hold", avs_readdata, 32'hF);
    checkOutput("hold valid", {31'b0, avs_readdatavalid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
